// File: rtl/alu_pkg.sv
// Shared constants and enums for the ALU arbiter and the single ALU it drives.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 2;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request strictly after i_ptr,
// wrapping around, so the last winner has lowest priority next time.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_grant_idx,
  output logic             o_any
);

  logic w_found;

  always_comb begin
    int k;
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    k           = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      k = (int'(i_ptr) + i) % N_REQ;
      if (!w_found && i_req[k]) begin
        w_found     = 1'b1;
        o_grant[k]  = 1'b1;
        o_grant_idx = ID_W'(k);
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among N_REQ requesters: accept, drive ALU for one
// cycle, capture the result and hold it on the response channel until taken.
module alu_arbiter #(
  parameter int  N_REQ  = 4,
  parameter int  DATA_W = alu_pkg::DATA_W,
  parameter int  OP_W   = alu_pkg::OP_W,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  input  logic [N_REQ*OP_W-1:0]   req_op,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  output logic [OP_W-1:0]         alu_opcode,
  input  logic [DATA_W-1:0]       alu_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       rsp_result,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    busy,
  output logic [15:0]             op_count
);

  import alu_pkg::*;

  arb_state_e        r_state;
  arb_state_e        w_next_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [N_REQ-1:0]  w_grant;
  logic [ID_W-1:0]   w_grant_idx;
  logic              w_any_valid;
  logic              w_accept;
  logic              w_exec;
  logic              w_handshake;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [OP_W-1:0]   r_alu_op;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_result;
  logic [ID_W-1:0]   r_rsp_id;
  logic [15:0]       r_op_count;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arbiter (
    .i_req       (req_valid),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_exec       = 1'b0;
    w_handshake  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any_valid) begin
          w_accept     = 1'b1;
          w_next_state = EXEC;
        end
      end
      EXEC: begin
        w_exec       = 1'b1;
        w_next_state = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          w_handshake  = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr     <= ID_W'(N_REQ - 1);
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_id     <= '0;
      r_op_count   <= '0;
    end else begin
      if (w_accept) begin
        r_alu_a  <= req_a[int'(w_grant_idx)*DATA_W +: DATA_W];
        r_alu_b  <= req_b[int'(w_grant_idx)*DATA_W +: DATA_W];
        r_alu_op <= req_op[int'(w_grant_idx)*OP_W +: OP_W];
        r_rsp_id <= w_grant_idx;
        r_rr_ptr <= w_grant_idx;
      end
      if (w_exec) begin
        r_rsp_result <= alu_result;
        r_rsp_valid  <= 1'b1;
      end
      if (w_handshake) begin
        r_rsp_valid <= 1'b0;
        r_op_count  <= sat_inc16(r_op_count);
      end
    end
  end

  // Grant is masked during reset so every output reads zero while rst_n is low.
  assign req_ready  = (r_state == IDLE && rst_n) ? w_grant : '0;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_opcode = r_alu_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_id     = r_rsp_id;
  assign busy       = (r_state != IDLE);
  assign op_count   = r_op_count;

endmodule
